// File: rtl/tdc_pkg.sv
// Shared constants, timestamp layout and the combinational helpers for the TDC encoder.
package tdc_pkg;
    localparam int CHAIN_LEN  = 32;
    localparam int FINE_W     = 6;
    localparam int COARSE_W   = 26;
    localparam int FIFO_DEPTH = 8;

    typedef struct packed {
        logic [COARSE_W-1:0] coarse;
        logic [FINE_W-1:0]   fine;
    } ts_t;

    // Three-tap majority vote; the edges are padded as "start reached" below and "not reached" above.
    function automatic logic [CHAIN_LEN-1:0] bubble_correct(input logic [CHAIN_LEN-1:0] therm);
        logic [CHAIN_LEN+1:0] ext;
        logic [CHAIN_LEN-1:0] corr;
        ext  = {1'b0, therm, 1'b1};
        corr = '0;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            corr[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
        return corr;
    endfunction

    function automatic logic [FINE_W-1:0] popcount(input logic [CHAIN_LEN-1:0] bits);
        logic [FINE_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            cnt = cnt + {{(FINE_W-1){1'b0}}, bits[i]};
        end
        return cnt;
    endfunction
endpackage

// File: rtl/tdc_ts_fifo.sv
// Timestamp FIFO: the head lives in a dedicated output register, the rest in a small array.
module tdc_ts_fifo
    import tdc_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_en,
    input  ts_t  wr_data,
    input  logic rd_en,
    output ts_t  rd_data,
    output logic rd_valid,
    output logic full,
    output logic empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    ts_t              mem_r [DEPTH];
    ts_t              head_r;
    logic             head_valid_r;
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] mem_cnt_r, total_s;
    logic             pop_s, push_s, load_s, from_mem_s, to_mem_s;

    // Occupancy and routing: a push bypasses the array only when the head refills from nothing else.
    always_comb begin
        total_s    = mem_cnt_r + {{PTR_W{1'b0}}, head_valid_r};
        pop_s      = head_valid_r & rd_en;
        push_s     = wr_en & ((total_s != CNT_FULL) | pop_s);
        load_s     = ~head_valid_r | pop_s;
        from_mem_s = load_s & (mem_cnt_r != '0);
        to_mem_s   = push_s & ~(load_s & (mem_cnt_r == '0));
    end

    // Array storage; contents are only meaningful below mem_cnt_r.
    always_ff @(posedge clk) begin
        if (to_mem_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and array-occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            mem_cnt_r <= '0;
        end else begin
            if (to_mem_s)   wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (from_mem_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({to_mem_s, from_mem_s})
                2'b10:   mem_cnt_r <= mem_cnt_r + CNT_ONE;
                2'b01:   mem_cnt_r <= mem_cnt_r - CNT_ONE;
                default: mem_cnt_r <= mem_cnt_r;
            endcase
        end
    end

    // Head register: holds steady until popped, then refills from the array or the incoming write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r       <= '0;
            head_valid_r <= 1'b0;
        end else if (from_mem_s) begin
            head_r       <= mem_r[rd_ptr_r];
            head_valid_r <= 1'b1;
        end else if (load_s && push_s) begin
            head_r       <= wr_data;
            head_valid_r <= 1'b1;
        end else if (load_s) begin
            head_valid_r <= 1'b0;
        end
    end

    assign rd_data  = head_r;
    assign rd_valid = head_valid_r;
    assign full     = (total_s == CNT_FULL);
    assign empty    = (total_s == '0);
endmodule

// File: rtl/tdc_encoder.sv
// Carry-chain TDC encoder: three-stage snapshot/bubble-fix/popcount pipeline feeding a timestamp FIFO.
module tdc_encoder #(
    parameter int CHAIN_LEN  = tdc_pkg::CHAIN_LEN,
    parameter int COARSE_W   = tdc_pkg::COARSE_W,
    parameter int FIFO_DEPTH = tdc_pkg::FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 hit_i,
    input  logic [CHAIN_LEN-1:0] therm_i,
    output logic [31:0]          ts_o,
    output logic                 ts_valid_o,
    input  logic                 ts_ready_i,
    output logic                 sat_o,
    output logic [15:0]          drop_cnt_o
);
    localparam int FINE_W = tdc_pkg::FINE_W;
    localparam logic [COARSE_W-1:0] COARSE_ONE = COARSE_W'(1);
    localparam logic [FINE_W-1:0]   FINE_SAT   = FINE_W'(CHAIN_LEN);

    logic [COARSE_W-1:0]  coarse_r, coarse1_r, coarse2_r, coarse3_r;
    logic [CHAIN_LEN-1:0] therm1_r, bub2_r;
    logic [FINE_W-1:0]    fine3_r;
    logic                 valid1_r, valid2_r, valid3_r;
    logic                 sat_r;
    logic [15:0]          drop_cnt_r;
    tdc_pkg::ts_t         wr_ts_s, head_s;
    logic                 head_valid_s, fifo_full_s, fifo_empty_s, drop_s;

    // Free-running coarse time base; wraps silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coarse_r <= '0;
        end else begin
            coarse_r <= coarse_r + COARSE_ONE;
        end
    end

    // Hit pipeline: S1 snapshot, S2 bubble correction, S3 popcount. Never stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid1_r  <= 1'b0;
            valid2_r  <= 1'b0;
            valid3_r  <= 1'b0;
            therm1_r  <= '0;
            bub2_r    <= '0;
            fine3_r   <= '0;
            coarse1_r <= '0;
            coarse2_r <= '0;
            coarse3_r <= '0;
        end else begin
            valid1_r <= hit_i & en_i;
            if (hit_i && en_i) begin
                therm1_r  <= therm_i;
                coarse1_r <= coarse_r;
            end
            valid2_r  <= valid1_r;
            bub2_r    <= tdc_pkg::bubble_correct(therm1_r);
            coarse2_r <= coarse1_r;
            valid3_r  <= valid2_r;
            fine3_r   <= tdc_pkg::popcount(bub2_r);
            coarse3_r <= coarse2_r;
        end
    end

    assign wr_ts_s = '{coarse: coarse3_r, fine: fine3_r};
    // A full FIFO still takes the write when the head is leaving in the same cycle.
    assign drop_s  = valid3_r & fifo_full_s & ~(ts_ready_i & ~fifo_empty_s);

    // Sticky saturation flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_r      <= 1'b0;
            drop_cnt_r <= 16'h0000;
        end else begin
            if (valid3_r && (fine3_r == FINE_SAT)) sat_r <= 1'b1;
            if (drop_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
    end

    tdc_ts_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (valid3_r),
        .wr_data  (wr_ts_s),
        .rd_en    (ts_ready_i),
        .rd_data  (head_s),
        .rd_valid (head_valid_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

    assign ts_o       = head_s;
    assign ts_valid_o = head_valid_s;
    assign sat_o      = sat_r;
    assign drop_cnt_o = drop_cnt_r;
endmodule

// File: doc/tdc_encoder.md
TDC_ENCODER -- requirements
Module: tdc_encoder

Interface
REQ-001 Parameter CHAIN_LEN, default 32: width of the thermometer snapshot from the carry-chain delay line.
REQ-002 Parameter COARSE_W, default 26: coarse counter width; COARSE_W + FINE_W SHALL equal 32.
REQ-003 Parameter FIFO_DEPTH, default 8: timestamp buffer entries, power of two.
REQ-004 clk  input  1: single clock; all logic is synchronous to its rising edge.
REQ-005 rst_n  input  1: synchronous, active-low reset.
REQ-006 en_i  input  1: high to accept hits; low ignores hits while the pipeline and FIFO drain normally.
REQ-007 hit_i  input  1: one-cycle strobe; therm_i is valid in the same cycle.
REQ-008 therm_i  input  CHAIN_LEN: thermometer snapshot, bit 0 nearest the start input.
REQ-009 ts_o  output  32: timestamp {coarse[COARSE_W-1:0], fine[5:0]}.
REQ-010 ts_valid_o  output  1: ts_o holds the FIFO head.
REQ-011 ts_ready_i  input  1: consumer accepts the head when it is high in the same cycle as ts_valid_o.
REQ-012 sat_o  output  1: sticky; set when any accepted hit has fine == CHAIN_LEN (chain saturated).
REQ-013 drop_cnt_o  output  16: hits lost because the FIFO was full; saturates at 0xFFFF.

Function
REQ-014 Coarse counter SHALL increment every cycle and wrap from 2^COARSE_W-1 to 0 without a flag.
REQ-015 Stage S1 (hit_i && en_i): register therm_i and the current coarse value; set valid1.
REQ-016 Stage S2: bubble correction; b[i] = majority(t[i-1], t[i], t[i+1]), with t[-1] = 1 and t[CHAIN_LEN] = 0.
REQ-017 Stage S3: fine = popcount(b), range 0..CHAIN_LEN, 6 bits; FIFO write request.
REQ-018 Latency: hit_i in cycle N -> FIFO write at the end of cycle N+3 -> ts_valid_o high in cycle N+4 if the FIFO was empty.
REQ-019 Pipeline SHALL accept hits on consecutive cycles at full rate with no stalls; ts_ready_i SHALL NOT back-pressure S1-S3.
REQ-020 FIFO full at an S3 write request: discard the entry and increment drop_cnt_o.
REQ-021 FIFO full with a simultaneous read (ts_valid_o && ts_ready_i) and S3 write: the write SHALL succeed; no drop.
REQ-022 FIFO empty with a simultaneous write: ts_valid_o rises the next cycle; no fall-through.
REQ-023 ts_o and ts_valid_o SHALL remain stable while ts_valid_o && !ts_ready_i.
REQ-024 fine == 0 (start edge not reached the chain) SHALL be buffered unchanged; it is not an error.
REQ-025 Order of timestamps at ts_o SHALL equal the order of hits.
REQ-026 en_i deasserting mid-pipeline SHALL NOT cancel hits already in S1-S3.

Reset
REQ-027 On a clk edge with rst_n low: coarse = 0, valid1..3 = 0, FIFO empty, ts_valid_o = 0, ts_o = 0, sat_o = 0, drop_cnt_o = 0.
REQ-028 Reset mid-operation SHALL discard all in-flight and buffered hits with no partial output.
REQ-029 The first coarse value after reset release SHALL be 0 in the cycle rst_n is first sampled high.

Structure
REQ-030 Package tdc_pkg SHALL hold CHAIN_LEN, FINE_W = 6, COARSE_W, and the timestamp struct {coarse, fine}.
REQ-031 The FIFO SHALL be a separate sub-module, tdc_ts_fifo: synchronous, registered output, full/empty flags, FIFO_DEPTH entries.
REQ-032 Bubble correction and popcount SHALL be pure combinational functions in tdc_pkg.

Verification
REQ-033 Reset, then hit with therm 0x0000_00FF at coarse 5 -> ts_o = {5, 8} 4 cycles later; sat_o = 0.
REQ-034 therm 0x0000_00F7 (bubble at bit 3) -> fine = 8; therm 0xFFFF_FFFF -> fine = 32 and sat_o = 1.
REQ-035 10 back-to-back hits with ts_ready_i = 0 -> 8 entries buffered, drop_cnt_o = 2; then ready = 1 -> first 8 out in order.
REQ-036 FIFO full, ts_ready_i = 1, and a hit arriving -> no drop; write and read happen in the same cycle.
REQ-037 Coarse preset to near wrap (hit at 2^26-1, then the next hit 2 cycles later) -> coarse fields 0x3FFFFFF then 1.
REQ-038 rst_n low for 1 cycle with 3 hits in flight and 4 buffered -> ts_valid_o = 0 and no stale output after release.
